// File: rtl/genius_round_ctrl.sv
// Round controller for the Genius memory game: grows the pattern by one element
// per round, plays it back on the LEDs and checks the player's presses against it.
module genius_round_ctrl #(
    parameter int MAX_LEVEL     = 15,
    parameter int ON_TICKS      = 25,
    parameter int OFF_TICKS     = 10,
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] btn,
    input  logic [1:0] seq_data,
    output logic [3:0] seq_addr,
    output logic       seq_we,
    output logic [2:0] leds,
    output logic [2:0] state,
    output logic [3:0] current_level,
    output logic [3:0] sequence_count,
    output logic       win,
    output logic       lose
);
    localparam int ON_OFF_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_MAX   = (ON_OFF_MAX > TIMEOUT_TICKS) ? ON_OFF_MAX : TIMEOUT_TICKS;
    localparam int TW         = $clog2(TICK_MAX + 1);

    localparam logic [TW-1:0] ON_LAST      = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST     = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]    LEVEL_TOP    = 4'(MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXTEND   = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_INPUT    = 3'd4,
        ST_WIN      = 3'd5,
        ST_LOSE     = 3'd6
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    level_reg, level_next;
    logic [3:0]    count_reg, count_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          start_q_reg;
    logic [2:0]    leds_reg, leds_next;
    logic          seq_we_reg, seq_we_next;
    logic [3:0]    seq_addr_reg, seq_addr_next;
    logic          win_reg, win_next;
    logic          lose_reg, lose_next;

    logic          start_event;
    logic [2:0]    expected_led;
    logic          last_element;

    // Colour code 3 is not a real colour; it is folded onto colour 0.
    function automatic logic [2:0] colour_onehot(input logic [1:0] c);
        case (c)
            2'd1:    colour_onehot = 3'b010;
            2'd2:    colour_onehot = 3'b100;
            default: colour_onehot = 3'b001;
        endcase
    endfunction

    assign start_event  = start & ~start_q_reg;
    assign expected_led = colour_onehot(seq_data);
    assign last_element = (count_reg == level_reg - 4'd1);

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        count_next = count_reg;
        timer_next = timer_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_event) begin
                    state_next = ST_EXTEND;
                end
            end
            ST_EXTEND: begin
                level_next = level_reg + 4'd1;
                count_next = 4'd0;
                timer_next = '0;
                state_next = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (tick) begin
                    if (timer_reg == ON_LAST) begin
                        timer_next = '0;
                        state_next = ST_SHOW_OFF;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            ST_SHOW_OFF: begin
                if (tick) begin
                    if (timer_reg == OFF_LAST) begin
                        timer_next = '0;
                        if (last_element) begin
                            count_next = 4'd0;
                            state_next = ST_INPUT;
                        end else begin
                            count_next = count_reg + 4'd1;
                            state_next = ST_SHOW_ON;
                        end
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            ST_INPUT: begin
                // A press in the same cycle as a tick takes priority over the timeout.
                if (btn != 3'b000) begin
                    if (btn == expected_led) begin
                        timer_next = '0;
                        if (last_element) begin
                            state_next = (level_reg == LEVEL_TOP) ? ST_WIN : ST_EXTEND;
                        end else begin
                            count_next = count_reg + 4'd1;
                        end
                    end else begin
                        state_next = ST_LOSE;
                    end
                end else if (tick) begin
                    if (timer_reg == TIMEOUT_LAST) begin
                        state_next = ST_LOSE;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start_event) begin
                    level_next = 4'd0;
                    state_next = ST_EXTEND;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values; during playback the LED
    // register samples the RAM one cycle after the address, so lit and dark phases
    // both appear one cycle late but keep their full lengths.
    always_comb begin
        seq_we_next   = (state_next == ST_EXTEND);
        seq_addr_next = (state_next == ST_EXTEND) ? level_next : count_next;
        win_next      = (state_next == ST_WIN);
        lose_next     = (state_next == ST_LOSE);
        leds_next     = 3'b000;
        if (state_next == ST_WIN) begin
            leds_next = 3'b111;
        end else if (state_reg == ST_SHOW_ON) begin
            leds_next = expected_led;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            level_reg    <= 4'd0;
            count_reg    <= 4'd0;
            timer_reg    <= '0;
            start_q_reg  <= 1'b0;
            leds_reg     <= 3'b000;
            seq_we_reg   <= 1'b0;
            seq_addr_reg <= 4'd0;
            win_reg      <= 1'b0;
            lose_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            count_reg    <= count_next;
            timer_reg    <= timer_next;
            start_q_reg  <= start;
            leds_reg     <= leds_next;
            seq_we_reg   <= seq_we_next;
            seq_addr_reg <= seq_addr_next;
            win_reg      <= win_next;
            lose_reg     <= lose_next;
        end
    end

    assign state          = state_reg;
    assign current_level  = level_reg;
    assign sequence_count = count_reg;
    assign leds           = leds_reg;
    assign seq_we         = seq_we_reg;
    assign seq_addr       = seq_addr_reg;
    assign win            = win_reg;
    assign lose           = lose_reg;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Bench for genius_round_ctrl: a game-level model checked every cycle plus
// hand-computed checkpoints through several short games.
module tb_genius_round_ctrl;
    localparam int MAXL = 2;
    localparam int ON   = 2;
    localparam int OFF  = 1;
    localparam int TO   = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic [2:0] btn;
    logic [1:0] seq_data;
    logic [3:0] seq_addr;
    logic       seq_we;
    logic [2:0] leds;
    logic [2:0] state;
    logic [3:0] current_level;
    logic [3:0] sequence_count;
    logic       win;
    logic       lose;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    genius_round_ctrl #(
        .MAX_LEVEL    (MAXL),
        .ON_TICKS     (ON),
        .OFF_TICKS    (OFF),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .start         (start),
        .btn           (btn),
        .seq_data      (seq_data),
        .seq_addr      (seq_addr),
        .seq_we        (seq_we),
        .leds          (leds),
        .state         (state),
        .current_level (current_level),
        .sequence_count(sequence_count),
        .win           (win),
        .lose          (lose)
    );

    // Pattern RAM plus "random" generator: the generator writes pattern[addr].
    logic [1:0] ram     [0:15];
    logic [1:0] pattern [0:15];
    assign seq_data = ram[seq_addr];
    always @(posedge clock) begin
        if (seq_we) ram[seq_addr] <= pattern[seq_addr];
    end

    function automatic logic [2:0] led_of(input logic [1:0] c);
        return 3'b001 << ((c == 2'd3) ? 0 : int'(c));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    // Game model: phase codes are the published state codes, timing kept as
    // remaining ticks, colours taken straight from the generator's pattern.
    int         m_phase, m_level, m_idx, m_left;
    logic       m_prev;
    logic       m_valid = 1'b0;
    logic [2:0] e_leds;
    logic       e_we, e_win, e_lose;
    logic [3:0] e_addr;

    initial begin : model
        logic       ev;
        logic [2:0] lit;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_phase = 0; m_level = 0; m_idx = 0; m_left = 0; m_prev = 1'b0;
                e_leds = 3'b000; e_we = 1'b0; e_addr = 4'd0; e_win = 1'b0; e_lose = 1'b0;
                m_valid = 1'b1;
            end else begin
                ev     = start && !m_prev;
                m_prev = start;
                lit    = 3'b000;
                case (m_phase)
                    0: if (ev) m_phase = 1;
                    1: begin
                        m_level++; m_idx = 0; m_left = ON; m_phase = 2;
                    end
                    2: begin
                        lit = led_of(pattern[m_idx]);
                        if (tick) begin
                            m_left--;
                            if (m_left == 0) begin m_phase = 3; m_left = OFF; end
                        end
                    end
                    3: if (tick) begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_idx == m_level - 1) begin m_phase = 4; m_idx = 0; m_left = TO; end
                            else begin m_idx++; m_phase = 2; m_left = ON; end
                        end
                    end
                    4: begin
                        if (btn != 3'b000) begin
                            if (btn == led_of(pattern[m_idx])) begin
                                m_left = TO;
                                if (m_idx == m_level - 1) m_phase = (m_level == MAXL) ? 5 : 1;
                                else m_idx++;
                            end else begin
                                m_phase = 6;
                            end
                        end else if (tick) begin
                            m_left--;
                            if (m_left == 0) m_phase = 6;
                        end
                    end
                    default: if (ev) begin m_level = 0; m_phase = 1; end
                endcase
                e_leds = (m_phase == 5) ? 3'b111 : lit;
                e_we   = (m_phase == 1);
                e_addr = (m_phase == 1) ? 4'(m_level) : 4'(m_idx);
                e_win  = (m_phase == 5);
                e_lose = (m_phase == 6);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clock);
            if (m_valid) begin
                check("state",    int'(state),          m_phase);
                check("level",    int'(current_level),  m_level);
                check("count",    int'(sequence_count), m_idx);
                check("leds",     int'(leds),           int'(e_leds));
                check("seq_we",   int'(seq_we),         int'(e_we));
                check("seq_addr", int'(seq_addr),       int'(e_addr));
                check("win",      int'(win),            int'(e_win));
                check("lose",     int'(lose),           int'(e_lose));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input int code, input int budget, input logic toggle_tick);
        int n = 0;
        while (int'(state) != code && n < budget) begin
            if (toggle_tick) tick = ~tick;
            @(negedge clock);
            n++;
        end
        check("wait_state", int'(state), code);
    endtask

    task automatic note(input string what);
        $display("txn %s: state=%0d level=%0d count=%0d leds=%b we=%b addr=%0d win=%b lose=%b",
                 what, state, current_level, sequence_count, leds, seq_we, seq_addr, win, lose);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int i = 0; i < 16; i++) pattern[i] = 2'd0;
        pattern[0] = 2'd1;
        pattern[1] = 2'd2;
        reset = 1'b1; start = 1'b0; tick = 1'b0; btn = 3'b000;
        step(2);
        check("rst_state", int'(state), 0);
        check("rst_level", int'(current_level), 0);
        check("rst_leds", int'(leds), 0);
        check("rst_we", int'(seq_we), 0);
        check("rst_win", int'(win), 0);
        check("rst_lose", int'(lose), 0);
        note("reset");
        reset = 1'b0; tick = 1'b1;
        step(1);
        check("idle_hold", int'(state), 0);

        // Game 1: playback of RAM[0]=1, boundary press on the last timeout tick.
        start = 1'b1;
        step(1);
        check("g1_extend", int'(state), 1);
        check("g1_we", int'(seq_we), 1);
        check("g1_addr", int'(seq_addr), 0);
        note("start game1");
        step(1);
        check("g1_on_dark", int'(leds), 0);
        check("g1_level1", int'(current_level), 1);
        step(1);
        check("g1_lit_a", int'(leds), 3'b010);
        step(1);
        check("g1_lit_b", int'(leds), 3'b010);
        check("g1_off", int'(state), 3);
        step(1);
        check("g1_input", int'(state), 4);
        check("g1_input_dark", int'(leds), 0);
        step(3);
        check("g1_before_timeout", int'(state), 4);
        btn = 3'b010;
        step(1);
        btn = 3'b000;
        check("g1_ok_extend", int'(state), 1);
        check("g1_ok_addr", int'(seq_addr), 1);
        check("g1_ok_we", int'(seq_we), 1);
        note("round1 correct");
        wait_state(4, 40, 1'b0);
        check("g1_r2_level", int'(current_level), 2);
        check("g1_r2_count", int'(sequence_count), 0);
        tick = 1'b0;
        step(5);
        check("g1_no_tick_hold", int'(state), 4);
        btn = 3'b010;
        step(1);
        btn = 3'b000;
        check("g1_count1", int'(sequence_count), 1);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        btn = 3'b100;
        step(1);
        btn = 3'b000;
        check("g1_win_state", int'(state), 5);
        check("g1_win_flag", int'(win), 1);
        check("g1_win_leds", int'(leds), 3'b111);
        note("win");
        step(3);
        check("g1_win_held", int'(state), 5);

        // Game 2: colour code 3 shows as colour 0, two-bit press loses.
        pattern[0] = 2'd3;
        pattern[1] = 2'd1;
        start = 1'b0;
        step(1);
        check("g1_no_restart", int'(state), 5);
        start = 1'b1; tick = 1'b1;
        step(1);
        check("g2_extend", int'(state), 1);
        check("g2_level0", int'(current_level), 0);
        check("g2_win_clr", int'(win), 0);
        note("start game2");
        step(1);
        btn = 3'b100;
        step(1);
        btn = 3'b000;
        check("g2_colour3", int'(leds), 3'b001);
        wait_state(4, 40, 1'b0);
        btn = 3'b011;
        step(1);
        btn = 3'b000;
        check("g2_lose_state", int'(state), 6);
        check("g2_lose_flag", int'(lose), 1);
        check("g2_lose_level", int'(current_level), 1);
        note("multi press");

        // Game 3: no press for TIMEOUT ticks.
        pattern[0] = 2'd2;
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        check("g3_extend", int'(state), 1);
        wait_state(4, 40, 1'b0);
        step(3);
        check("g3_pre_timeout", int'(state), 4);
        step(1);
        check("g3_timeout", int'(state), 6);
        note("timeout");

        // Game 4: sparse ticks, then a wrong single-colour press.
        pattern[0] = 2'd1;
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        wait_state(4, 80, 1'b1);
        btn = 3'b001;
        step(1);
        btn = 3'b000;
        check("g4_wrong", int'(state), 6);
        check("g4_level", int'(current_level), 1);
        note("wrong press");

        // Game 5: reset in the middle of playback.
        tick = 1'b1;
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        wait_state(2, 10, 1'b0);
        step(1);
        check("g5_lit", int'(leds), 3'b010);
        reset = 1'b1; start = 1'b0;
        step(1);
        check("g5_rst_state", int'(state), 0);
        check("g5_rst_leds", int'(leds), 0);
        check("g5_rst_level", int'(current_level), 0);
        reset = 1'b0;
        step(1);
        check("g5_idle", int'(state), 0);
        note("mid-round reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/genius_round_ctrl.md
Name: genius_round_ctrl

Overview:
Round controller for the Genius memory game. It sequences the pattern memory: it requests a new element each round, plays the stored sequence on three LEDs with timed on/off phases, then checks player button presses against the sequence. Level and progress are tracked here, and the block ends in WIN or LOSE. It sits between the debounced button/prescaler logic and the pattern RAM/random generator, and its state/level/count outputs feed the seven-segment display logic.

Parameters:
MAX_LEVEL, 15, sequence length that produces WIN (1..15)
ON_TICKS, 25, tick strobes an LED stays lit during playback (>=1)
OFF_TICKS, 10, tick strobes of dark gap after each element (>=1)
TIMEOUT_TICKS, 100, tick strobes allowed between presses in INPUT (>=1)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
tick  in  1  one-cycle prescaler strobe, timing base
start  in  1  level input; internally rising-edge detected
btn  in  3  debounced one-cycle press pulses, bit i = colour i
seq_data  in  2  combinational read data of pattern RAM at seq_addr; value 3 treated as colour 0
seq_addr  out  4  pattern RAM address
seq_we  out  1  one-cycle request: generator writes random colour at seq_addr
leds  out  3  one-hot colour display
state  out  3  current FSM state code
current_level  out  4  sequence length of current round
sequence_count  out  4  index of element being shown/checked
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
- Reset (any state, mid-round included): next edge state=IDLE(0), current_level=0, sequence_count=0, leds=0, seq_we=0, win=0, lose=0, tick timer=0, start edge register=0. Registered outputs; seq_addr registered.
- Start edge: start_q sampled each cycle; event = start & ~start_q. start held high counts once.
- States: IDLE=0, EXTEND=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, WIN=5, LOSE=6.
- IDLE: start event -> EXTEND.
- EXTEND (exactly 1 cycle): seq_we=1, seq_addr=current_level; next: current_level+1, sequence_count=0, timer=0 -> SHOW_ON.
- SHOW_ON: seq_addr=sequence_count, leds=one-hot(seq_data) (from next cycle, 1-cycle latency); timer increments on tick; ON_TICKS ticks reached -> SHOW_OFF, timer=0, leds=0.
- SHOW_OFF: leds=0; OFF_TICKS ticks reached: if sequence_count==current_level-1 -> INPUT, sequence_count=0; else sequence_count+1 -> SHOW_ON. timer=0 on exit.
- INPUT: seq_addr=sequence_count, leds=0. btn!=0 evaluated same cycle:
  - btn == one-hot(seq_data): timer=0; if last element: current_level==MAX_LEVEL -> WIN else -> EXTEND; otherwise sequence_count+1.
  - btn mismatch or >1 bit set -> LOSE.
  - no press and TIMEOUT_TICKS ticks elapsed -> LOSE.
  - btn and tick same cycle: press wins, timer cleared.
- btn ignored in all states except INPUT; tick ignored in IDLE/EXTEND/WIN/LOSE.
- WIN: win=1, leds=3'b111. LOSE: lose=1, leds=0. Both hold current_level/sequence_count. Start event -> current_level=0, win=lose=0 -> EXTEND.
- Counters never wrap: current_level capped by MAX_LEVEL; timer width holds max(ON,OFF,TIMEOUT).

Test Plan:
- Reset/idle: reset 2 cycles, start held 0 -> state=0, level=0, leds=0, seq_we=0, win=lose=0.
- Playback (MAX_LEVEL=2, ON=2, OFF=1, tick every cycle, RAM[0]=1): start 0->1 -> seq_we one cycle at addr 0, leds=3'b010 for 2 cycles, 0 for 1 cycle, state=4.
- Correct round: in INPUT press btn=3'b010 -> state=EXTEND, level=2, seq_we at addr 1; replay two elements.
- Win: level 2, RAM={1,2}, press 010 then 100 -> state=5, win=1, leds=111; start held high further -> no restart until new rising edge.
- Wrong/multi press: in INPUT btn=3'b011 -> state=6, lose=1, level unchanged.
- Timeout and reset: TIMEOUT=4, no press for 4 ticks -> LOSE; reset asserted during SHOW_ON -> IDLE, leds=0 next edge.
